// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise and de-glitch the raw clock/data pair, frame
// 11-bit serial words, and fold E0/F0 prefixes into single key make/break events.

module ps2_glitch_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o
);
    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sync_d  = {sync_q[0], raw_i};
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Presetting to 1 models an idle bus, so reset never fakes a falling edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

    logic          clk_f, data_f, fall;
    logic          clk_prev_q;
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d, stop_q, stop_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          strobe_q, strobe_d, err_q, err_d;
    logic          pressed_q, pressed_d, extended_q, extended_d;
    logic [7:0]    code_q, code_d;
    logic          frame_ok;

    ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys(clk_sys), .reset_n(reset_n), .raw_i(ps2_clk),  .level_o(clk_f)
    );
    ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys(clk_sys), .reset_n(reset_n), .raw_i(ps2_data), .level_o(data_f)
    );

    assign fall     = clk_prev_q & ~clk_f;
    assign frame_ok = (^shift_q ^ parity_q) & stop_q;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        stop_d     = stop_q;
        tmo_d      = tmo_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        code_d     = code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_f) begin
                        state_d  = ST_SHIFT;
                        bitcnt_d = '0;
                        tmo_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (fall) begin
                    tmo_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        shift_d = {data_f, shift_q[7:1]};
                    end else if (bitcnt_q == 4'd8) begin
                        parity_d = data_f;
                    end else begin
                        stop_d  = data_f;
                        state_d = ST_CHECK;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!frame_ok) begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    case (shift_q)
                        8'hE0: ext_d = 1'b1;
                        8'hF0: brk_d = 1'b1;
                        // Keyboard housekeeping replies, never key codes.
                        8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                        default: begin
                            strobe_d   = 1'b1;
                            code_d     = shift_q;
                            pressed_d  = ~brk_q;
                            extended_d = ext_q;
                            ext_d      = 1'b0;
                            brk_d      = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_q     <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            code_q     <= 8'h00;
        end else begin
            clk_prev_q <= clk_f;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            stop_q     <= stop_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            code_q     <= code_d;
        end
    end

    assign key_strobe   = strobe_q;
    assign key_pressed  = pressed_q;
    assign key_extended = extended_q;
    assign key_code     = code_q;
    assign frame_err    = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: PS/2 frames are bit-banged on the raw pins and
// the resulting key events and error pulses are compared against hand-computed values.

module tb_ps2_scancode_rx;
    localparam int FL  = 4;
    localparam int TMO = 400;
    localparam int HB  = 20;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe, key_pressed, key_extended, frame_err;
    logic [7:0] key_code;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int strobe_cnt = 0, err_cnt = 0, both_cnt = 0;
    int strobe_cyc = 0, err_cyc = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_pressed = 1'b0, last_ext = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_strobe(key_strobe), .key_pressed(key_pressed), .key_extended(key_extended),
        .key_code(key_code), .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (key_strobe) begin
            strobe_cnt++;
            strobe_cyc   = cyc;
            last_code    = key_code;
            last_pressed = key_pressed;
            last_ext     = key_extended;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (key_strobe && frame_err) both_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        check_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_sys);
        ps2_data = b;
        idle(HB / 2);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        idle(HB);
        ps2_clk = 1'b1;
        idle(HB / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        idle(20);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(5);
        chk("reset key_strobe", key_strobe, 0);
        chk("reset key_pressed", key_pressed, 0);
        chk("reset key_extended", key_extended, 0);
        chk("reset key_code", key_code, 8'h00);
        chk("reset frame_err", frame_err, 0);
        reset_n = 1'b1;
        idle(20);
    endtask

    task automatic test_single_make;
        int s0 = strobe_cnt, e0 = err_cnt;
        send_frame(8'h1C, 1'b0);
        chk("make1C strobes", strobe_cnt - s0, 1);
        chk("make1C code", last_code, 8'h1C);
        chk("make1C pressed", last_pressed, 1);
        chk("make1C extended", last_ext, 0);
        chk("make1C latency", strobe_cyc - last_fall_cyc, FL + 4);
        chk("make1C no err", err_cnt - e0, 0);
        chk("make1C code held", key_code, 8'h1C);
        chk("strobe single cycle", key_strobe, 0);
    endtask

    task automatic test_prefix_fold;
        int s0 = strobe_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        chk("E0 F0 no strobe", strobe_cnt - s0, 0);
        send_frame(8'h75, 1'b0);
        chk("E0F075 strobes", strobe_cnt - s0, 1);
        chk("E0F075 code", last_code, 8'h75);
        chk("E0F075 pressed", last_pressed, 0);
        chk("E0F075 extended", last_ext, 1);
        send_frame(8'h75, 1'b0);
        chk("75 after fold strobes", strobe_cnt - s0, 2);
        chk("75 after fold pressed", last_pressed, 1);
        chk("75 after fold extended", last_ext, 0);
        send_frame(8'h75, 1'b0);
        chk("typematic 75 strobes", strobe_cnt - s0, 3);
        send_frame(8'hF0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("F0F01C code", last_code, 8'h1C);
        chk("F0F01C pressed", last_pressed, 0);
        chk("F0F01C extended", last_ext, 0);
    endtask

    task automatic test_discard;
        int s0 = strobe_cnt;
        send_frame(8'hAA, 1'b0);
        chk("AA no strobe", strobe_cnt - s0, 0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hFA, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("E0FA1C strobes", strobe_cnt - s0, 1);
        chk("E0FA1C extended", last_ext, 0);
    endtask

    task automatic test_parity_err;
        int s0 = strobe_cnt, e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        chk("bad parity err", err_cnt - e0, 1);
        chk("bad parity no strobe", strobe_cnt - s0, 0);
        send_frame(8'h1C, 1'b0);
        chk("good after bad strobes", strobe_cnt - s0, 1);
        chk("good after bad code", last_code, 8'h1C);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h42, 1'b1);
        send_frame(8'h6B, 1'b0);
        chk("E0 bad 6B strobes", strobe_cnt - s0, 2);
        chk("E0 bad 6B code", last_code, 8'h6B);
        chk("E0 bad 6B extended", last_ext, 0);
        chk("E0 bad 6B errs", err_cnt - e0, 2);
    endtask

    task automatic test_timeout;
        int s0 = strobe_cnt, e0 = err_cnt, dt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        ps2_data = 1'b1;
        idle(TMO + 60);
        dt = err_cyc - last_fall_cyc;
        chk("timeout one err", err_cnt - e0, 1);
        chk("timeout window", int'(dt >= FL + 2 + TMO && dt <= FL + 4 + TMO), 1);
        chk("timeout no strobe", strobe_cnt - s0, 0);
        send_frame(8'h29, 1'b0);
        chk("after timeout strobes", strobe_cnt - s0, 1);
        chk("after timeout code", last_code, 8'h29);
    endtask

    task automatic test_glitch;
        int s0 = strobe_cnt, e0 = err_cnt;
        ps2_data = 1'b1;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        idle(FL - 1);
        ps2_clk = 1'b1;
        idle(30);
        chk("short glitch no err", err_cnt - e0, 0);
        ps2_clk = 1'b0;
        idle(FL);
        ps2_clk = 1'b1;
        idle(30);
        chk("long glitch err", err_cnt - e0, 1);
        chk("glitch no strobe", strobe_cnt - s0, 0);
        send_frame(8'h1C, 1'b0);
        chk("post glitch frame", strobe_cnt - s0, 1);
    endtask

    task automatic test_reset_midframe;
        int s0;
        logic [7:0] b;
        b = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("midreset key_code", key_code, 8'h00);
        chk("midreset key_pressed", key_pressed, 0);
        chk("midreset key_strobe", key_strobe, 0);
        chk("midreset frame_err", frame_err, 0);
        reset_n = 1'b1;
        s0 = strobe_cnt;
        for (int i = 4; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        send_bit(1'b1);
        ps2_data = 1'b1;
        idle(TMO + 60);
        chk("remnant no strobe", strobe_cnt - s0, 0);
        send_frame(8'h16, 1'b0);
        chk("post reset strobes", strobe_cnt - s0, 1);
        chk("post reset code", last_code, 8'h16);
        chk("post reset pressed", last_pressed, 1);
    endtask

    initial begin
        test_reset;
        test_single_make;
        test_prefix_fold;
        test_discard;
        test_parity_err;
        test_timeout;
        test_glitch;
        test_reset_midframe;
        chk("strobe and err never together", both_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives the raw PS/2 keyboard clock/data pair and turns it into single-cycle scancode events: key_strobe, key_pressed, key_extended, key_code.
- Sits directly upstream of the Oric keyboard matrix and drives its key_* inputs.
- Handles synchronisation, glitch filtering, 11-bit frame reception, odd-parity check, frame timeout, and E0/F0 prefix folding.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clk/ps2_data level changes (min 2)
TIMEOUT, 50000, clk_sys cycles without a filtered falling ps2_clk edge mid-frame before the frame is aborted

Ports:
clk_sys  input  1  system clock, single clock domain
reset_n  input  1  synchronous reset, active-low, sampled on rising clk_sys
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
key_strobe  output  1  one-cycle pulse: new key event valid
key_pressed  output  1  1 = make, 0 = break; valid with key_strobe
key_extended  output  1  1 = code was E0-prefixed; valid with key_strobe
key_code  output  8  scancode byte; valid with key_strobe
frame_err  output  1  one-cycle pulse on start, parity or stop error, or on timeout

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): all outputs 0, key_code=8'h00, FSM=IDLE, prefix flags clear, filters preset to 1 (idle bus), counters 0. Reset takes effect immediately mid-frame and discards any partial frame.
- Input path: ps2_clk and ps2_data each pass through a 2-FF synchroniser, then a filter.
  - The filter output changes only after FILTER_LEN consecutive identical synchronised samples.
  - Any shorter pulse is ignored.
- Edge detect: fall = filtered_clk_prev & ~filtered_clk. Data is sampled as filtered ps2_data in the same cycle as fall.
- FSM IDLE:
  - On fall with data=0 (start bit): go to SHIFT, bitcnt=0, timeout counter cleared.
  - On fall with data=1: pulse frame_err and stay in IDLE.
- FSM SHIFT, on each fall:
  - bitcnt 0..7: shift data in LSB-first.
  - bitcnt 8: parity bit.
  - bitcnt 9: stop bit, then go to CHECK.
  - bitcnt increments each fall.
- FSM CHECK (one cycle): frame is good iff (^data8 ^ parity)==1 and stop==1.
  - Bad frame: pulse frame_err, clear both prefix flags, go to IDLE.
  - Good frame, byte E0: set ext flag, no strobe.
  - Good frame, byte F0: set brk flag, no strobe.
  - Good frame, byte in {00, AA, E1, EE, FA, FE, FF}: discard, clear both flags, no strobe.
  - Any other good byte: on the next cycle key_strobe=1, key_code=byte, key_pressed=~brk, key_extended=ext; then clear both flags.
  - Return to IDLE.
- Latency: key_strobe is asserted exactly 2 clk_sys cycles after the cycle in which the stop-bit fall is detected. One cycle enters CHECK; the output register fires on the next.
- key_code, key_pressed and key_extended hold their value after the strobe until the next strobe.
- key_strobe and frame_err never assert in the same cycle.
- Timeout:
  - In SHIFT the timeout counter increments every cycle and resets on each fall.
  - When it reaches TIMEOUT-1: pulse frame_err, go to IDLE, clear prefix flags.
  - The counter saturates and never wraps.
- Prefix order: E0 then F0, or F0 alone, both fold into one event. A repeated prefix is idempotent.
- A fall arriving during CHECK is not possible at PS/2 rates. If one does arrive, it is ignored.
- Typematic repeats (same make code again) each produce a new strobe.

Test Plan:
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1), FILTER_LEN=4 -> exactly one key_strobe with key_code=1C, pressed=1, extended=0, 2 cycles after the stop-bit fall; frame_err stays 0.
- Frames E0, F0, 75 -> only one strobe, on the third frame, with code=75, pressed=0, extended=1. The next frame 0x75 strobes with pressed=1, extended=0.
- Frame 0x1C with parity bit 1 -> frame_err pulse, no strobe. A following good 0x1C strobes normally. Also send E0, then a bad frame, then 6B -> strobe extended=0.
- 4 data bits, then silence > TIMEOUT -> one frame_err pulse at TIMEOUT cycles after the last fall, FSM back in IDLE. A subsequent full frame 0x29 strobes code=29.
- ps2_clk low glitch of FILTER_LEN-1 cycles while idle -> no state change, no frame_err. A glitch of FILTER_LEN cycles with data=1 -> frame_err.
- reset_n low for 1 cycle after the 5th bit of a frame -> all outputs 0. The remaining bits then produce no strobe, only a possible frame_err. A next clean frame 0x16 strobes code=16.
